// File: rtl/reg_bus_pkg.sv
// reg_bus_pkg: shared state encoding, default bus widths and direction codes
// for the addr_en/rw_direction register-bus initiator and its timeout counter.
package reg_bus_pkg;

    // Default widths of the register bus.
    localparam int REG_BUS_ADDR_W = 32;
    localparam int REG_BUS_DATA_W = 32;

    // Values driven on rw_direction.
    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    // Transaction sequencer states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Width of a counter that must be able to hold the value 'cycles'.
    function automatic int timer_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/reg_bus_timer.sv
// reg_bus_timer: read-wait counter for the register-bus initiator.
// Cleared when a read strobe goes out, counts every waiting cycle, and flags
// expiry once it has counted TIMEOUT_CYCLES-1 cycles. It saturates instead of
// wrapping so a stuck enable can never make it expire a second time.
// Only instantiated when REG_BUS_MASTER_TIMEOUT_EN is defined.
module reg_bus_timer
    import reg_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
)(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int            TW   = timer_width(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] SAT  = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] r_count;

    // Count waiting cycles; clear has priority, saturate at TIMEOUT_CYCLES.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != SAT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == LAST);

endmodule

// File: rtl/reg_bus_master.sv
// reg_bus_master: initiator for the addr_en/rw_direction register bus.
// Takes one command at a time from the cmd_* port, issues a single-cycle bus
// strobe, waits for rvalid on reads and returns the result on the rsp_* port.
//
// Handshakes: a command transfers on a cycle with cmd_valid && cmd_ready, a
// response transfers on a cycle with rsp_valid && rsp_ready; once rsp_valid is
// raised it and all rsp_* fields stay unchanged until that transfer.
//
// Build option REG_BUS_MASTER_TIMEOUT_EN: when defined, a read that sees no
// rvalid within TIMEOUT_CYCLES waiting cycles completes with rsp_error=1.
// When undefined, reads wait indefinitely and rsp_error is constant 0.
module reg_bus_master
    import reg_bus_pkg::*;
#(
    parameter int ADDR_W         = REG_BUS_ADDR_W,
    parameter int DATA_W         = REG_BUS_DATA_W,
    parameter int TIMEOUT_CYCLES = 16
)(
    input  logic              clk,
    input  logic              reset_n,
    // command port
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    // response port
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error,
    // register bus
    output logic              addr_en,
    output logic              rw_direction,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    input  logic              rvalid,
    // debug view of the sequencer
    output state_t            o_dbg_state
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("reg_bus_master: TIMEOUT_CYCLES must be at least 1");
    end

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_addr_en;
    logic              w_addr_en_nxt;
    logic              r_rw;
    logic              w_rw_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] w_wdata_nxt;
    logic              r_rsp_valid;
    logic              w_rsp_valid_nxt;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic [DATA_W-1:0] w_rsp_rdata_nxt;

`ifdef REG_BUS_MASTER_TIMEOUT_EN
    logic r_rsp_error;
    logic w_rsp_error_nxt;
    logic w_timer_clear;
    logic w_timer_en;
    logic w_timer_expired;

    reg_bus_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .i_clk     (clk),
        .i_rst_n   (reset_n),
        .i_clear   (w_timer_clear),
        .i_enable  (w_timer_en),
        .o_expired (w_timer_expired)
    );
`endif

    // Next-state and next-output decode. The bus address/data/direction
    // registers double as the command latch: they load on the accept edge so
    // they are already valid in the strobe cycle, then hold afterwards.
    always_comb begin
        w_state_nxt     = r_state;
        w_addr_en_nxt   = 1'b0;
        w_rw_nxt        = r_rw;
        w_addr_nxt      = r_addr;
        w_wdata_nxt     = r_wdata;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_rdata_nxt = r_rsp_rdata;
`ifdef REG_BUS_MASTER_TIMEOUT_EN
        w_rsp_error_nxt = r_rsp_error;
        w_timer_clear   = 1'b0;
        w_timer_en      = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    w_state_nxt   = STROBE;
                    w_addr_en_nxt = 1'b1;
                    w_rw_nxt      = cmd_write;
                    w_addr_nxt    = cmd_addr;
                    w_wdata_nxt   = cmd_wdata;
                end
            end
            STROBE: begin
                if (r_rw == RW_WRITE) begin
                    // Writes complete without waiting for the responder.
                    w_state_nxt     = RESP;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = '0;
`ifdef REG_BUS_MASTER_TIMEOUT_EN
                    w_rsp_error_nxt = 1'b0;
`endif
                end else begin
                    w_state_nxt = WAIT;
`ifdef REG_BUS_MASTER_TIMEOUT_EN
                    w_timer_clear = 1'b1;
`endif
                end
            end
            WAIT: begin
                // rvalid is checked first so it wins over a same-cycle expiry.
                if (rvalid) begin
                    w_state_nxt     = RESP;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = rdata;
`ifdef REG_BUS_MASTER_TIMEOUT_EN
                    w_rsp_error_nxt = 1'b0;
                end else if (w_timer_expired) begin
                    w_state_nxt     = RESP;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = '0;
                    w_rsp_error_nxt = 1'b1;
                end else begin
                    w_timer_en = 1'b1;
`endif
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_nxt     = IDLE;
                    w_rsp_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered bus and response outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr_en   <= 1'b0;
            r_rw        <= RW_READ;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_addr_en   <= w_addr_en_nxt;
            r_rw        <= w_rw_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
        end
    end

`ifdef REG_BUS_MASTER_TIMEOUT_EN
    // Timeout error flag, only present when the timeout is built in.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rsp_error <= 1'b0;
        end else begin
            r_rsp_error <= w_rsp_error_nxt;
        end
    end

    assign rsp_error = r_rsp_error;
`else
    assign rsp_error = 1'b0;
`endif

    assign cmd_ready    = (r_state == IDLE);
    assign addr_en      = r_addr_en;
    assign rw_direction = r_rw;
    assign addr         = r_addr;
    assign wdata        = r_wdata;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_rdata    = r_rsp_rdata;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_reg_bus_master.sv
// tb_reg_bus_master: directed bench for reg_bus_master. Driver tasks issue
// commands and play the responder; expected bus strobes and responses are
// derived at transaction level (which cycle, which data, error or not) and
// checked by one monitor on every falling edge.
module tb_reg_bus_master;
  import reg_bus_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  initial forever #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // ---------------- DUT ----------------
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_error;
  logic [DW-1:0] rsp_rdata;
  logic          addr_en, rw_direction;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          rvalid;
  state_t        dbg_state;

  reg_bus_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error),
    .addr_en(addr_en), .rw_direction(rw_direction), .addr(addr), .wdata(wdata),
    .rdata(rdata), .rvalid(rvalid), .o_dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  // {strobe cycle[32], rw, addr[32], wdata[32]}
  logic [96:0] bus_q[$];
  // {first rsp_valid cycle[32], error, rdata[32]}
  logic [64:0] rsp_q[$];
  logic        busy = 1'b0;
  int          cur_t1 = 0;
  int          acc_cyc = 0;
  int          hs_cyc = 0;
  int          first_cyc = 0;
  int          last_rsp_t = 0;
  int          last_strobe_rel = 0;
  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0;
  logic        prev_valid = 1'b0;
  logic        hold_prev = 1'b0;
  logic [31:0] held_rdata = '0;
  logic        held_err = 1'b0;
  logic [31:0] last_addr = '0;
  logic        last_rw = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc_cnt);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    logic [96:0] be;
    logic [64:0] re;
    if (!reset_n) begin
      prev_valid = 1'b0;
      hold_prev  = 1'b0;
      last_addr  = '0;
      last_rw    = 1'b0;
    end else begin
      chk("cmd_ready", cmd_ready, !busy);
      if (addr_en) begin
        if (bus_q.size() == 0) flag("strobe_unexpected");
        else begin
          be = bus_q.pop_front();
          last_strobe_rel = cyc_cnt - acc_cyc;
          chk("strobe_cycle", cyc_cnt, be[96:65]);
          chk("strobe_rw", rw_direction, be[64]);
          chk("strobe_addr", addr, be[63:32]);
          if (be[64]) chk("strobe_wdata", wdata, be[31:0]);
          last_addr = be[63:32];
          last_rw   = be[64];
        end
      end else begin
        chk("addr_hold", addr, last_addr);
        chk("rw_hold", rw_direction, last_rw);
      end
      if (rsp_valid && !prev_valid) first_cyc = cyc_cnt;
      if (rsp_valid && hold_prev) begin
        chk("rsp_hold_rdata", rsp_rdata, held_rdata);
        chk("rsp_hold_error", rsp_error, held_err);
      end
      if (rsp_valid && rsp_ready) begin
        if (rsp_q.size() == 0) flag("rsp_unexpected");
        else begin
          re = rsp_q.pop_front();
          chk("rsp_cycle", first_cyc, re[64:33]);
          chk("rsp_error", rsp_error, re[32]);
          chk("rsp_rdata", rsp_rdata, re[31:0]);
        end
        busy       = 1'b0;
        hs_cyc     = cyc_cnt;
        last_rsp_t = first_cyc - cur_t1 + 1;
        last_rdata = rsp_rdata;
        last_err   = rsp_error;
      end
      hold_prev  = rsp_valid && !rsp_ready;
      held_rdata = rsp_rdata;
      held_err   = rsp_error;
      prev_valid = rsp_valid;
    end
  end

  // ---------------- driver tasks ----------------
  // Present a command and return just after the accept edge (inside T1).
  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) flag("accept_timeout");
    acc_cyc = cyc_cnt;
    bus_q.push_back({32'(acc_cyc + 1), wr, a, d});
    @(posedge clk); #1;
    cur_t1 = cyc_cnt;
    busy = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom;
  endtask

  task automatic wait_done();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    if (busy) begin
      flag("response_timeout");
      busy = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    issue(RW_WRITE, a, d);
    rsp_q.push_back({32'(cur_t1 + 1), 1'b0, 32'h0});
    wait_done();
  endtask

  // Read whose rvalid arrives k cycles after the first waiting cycle.
  task automatic do_read(input logic [31:0] a, input logic [31:0] d, input int k);
    logic        err;
    logic [31:0] ed;
    int          lat;
    issue(RW_READ, a, $urandom);
`ifdef REG_BUS_MASTER_TIMEOUT_EN
    if (k < TO) begin err = 1'b0; ed = d; lat = 3 + k; end
    else begin err = 1'b1; ed = 32'h0; lat = 2 + TO; end
`else
    err = 1'b0; ed = d; lat = 3 + k;
`endif
    rsp_q.push_back({32'(cur_t1 + lat - 1), err, ed});
    repeat (k + 1) @(posedge clk);
    #1;
    rvalid = 1'b1; rdata = d;
    @(posedge clk); #1;
    rvalid = 1'b0; rdata = $urandom;
    wait_done();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_addr_en"}, addr_en, 1'b0);
    chk({tag, "_rw"}, rw_direction, 1'b0);
    chk({tag, "_addr"}, addr, 32'h0);
    chk({tag, "_wdata"}, wdata, 32'h0);
    chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
    chk({tag, "_rsp_error"}, rsp_error, 1'b0);
    chk({tag, "_state"}, dbg_state, IDLE);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b1; rdata = 32'hDEAD_BEEF; rvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    reset_n = 1'b1;
    @(posedge clk); #1;

    // 1: write
    do_write(32'h0, 32'h1234);
    chk("t1_strobe_latency", last_strobe_rel, 1);
    chk("t1_rsp_latency", last_rsp_t, 2);
    chk("t1_rsp_error", last_err, 1'b0);
    chk("t1_rsp_rdata", last_rdata, 32'h0);

    // 2: nominal read
    do_read(32'h0, 32'h1234, 0);
    chk("t2_rsp_latency", last_rsp_t, 3);
    chk("t2_rsp_rdata", last_rdata, 32'h1234);
    chk("t2_rsp_error", last_err, 1'b0);

    // 3: rvalid far too late
    do_read(32'h10, 32'hBEEF, 20);
`ifdef REG_BUS_MASTER_TIMEOUT_EN
    chk("t3_rsp_latency", last_rsp_t, 18);
    chk("t3_rsp_error", last_err, 1'b1);
    chk("t3_rsp_rdata", last_rdata, 32'h0);
`else
    chk("t3_rsp_latency", last_rsp_t, 23);
    chk("t3_rsp_error", last_err, 1'b0);
    chk("t3_rsp_rdata", last_rdata, 32'hBEEF);
`endif
    chk("t3_state_idle", dbg_state, IDLE);

    // 4: response stalled five cycles, then back-to-back command
    rsp_ready = 1'b0;
    issue(RW_READ, 32'h8, 32'h0);
    rsp_q.push_back({32'(cur_t1 + 2), 1'b0, 32'hCAFE});
    @(posedge clk); #1;
    rvalid = 1'b1; rdata = 32'hCAFE;
    @(posedge clk); #1;
    rvalid = 1'b0; rdata = $urandom;
    repeat (5) @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    wait_done();
    chk("t4_handshake_cycle", hs_cyc - cur_t1 + 1, 8);
    issue(RW_WRITE, 32'hC, 32'h5A5A);
    chk("t4_b2b_accept", acc_cyc, hs_cyc + 1);
    rsp_q.push_back({32'(cur_t1 + 1), 1'b0, 32'h0});
    wait_done();

    // 5: reset during WAIT drops the read
    issue(RW_READ, 32'h40, 32'h0);
    repeat (3) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    busy = 1'b0;
    bus_q.delete();
    rsp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    do_write(32'h30, 32'hA5A5_0001);
    chk("t5_rsp_latency", last_rsp_t, 2);

    // 6: stray rvalid in IDLE, then rvalid on the expiry cycle
    rvalid = 1'b1; rdata = 32'h777;
    @(posedge clk); #1;
    rvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("t6_idle_state", dbg_state, IDLE);
    chk("t6_idle_rsp_valid", rsp_valid, 1'b0);
    do_read(32'h20, 32'h600D, TO - 1);
    chk("t6_rsp_latency", last_rsp_t, 18);
    chk("t6_rsp_error", last_err, 1'b0);
    chk("t6_rsp_rdata", last_rdata, 32'h600D);

    // mixed traffic
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 1) == 1) do_write($urandom, $urandom);
      else do_read($urandom, $urandom, $urandom_range(0, 5));
    end

    chk("queues_drained", 64'(bus_q.size() + rsp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global bound on the run.
  initial begin
    #400000;
    flag("watchdog");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
